// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: opcodes, fixed registers, ALU codes and halt FSM states.
package decode_pkg;

  localparam int unsigned OP_ADD         = 0;
  localparam int unsigned OP_SUB         = 1;
  localparam int unsigned OP_MOV         = 2;
  localparam int unsigned OP_IMM         = 3;
  localparam int unsigned OP_SETQ        = 4;
  localparam int unsigned OP_CNTDEC      = 5;
  localparam int unsigned OP_BGTE        = 8;
  localparam int unsigned OP_BLTZ        = 9;
  localparam int unsigned OP_BEZ         = 10;
  localparam int unsigned OP_BE          = 11;
  localparam int unsigned OP_BNE         = 12;
  localparam int unsigned OP_JMP         = 13;
  localparam int unsigned OP_LD          = 22;
  localparam int unsigned OP_ST          = 23;
  localparam int unsigned OP_HALT        = 26;
  localparam int unsigned OP_ILLEGAL_MIN = 27;

  localparam int unsigned REG_ADR  = 4;
  localparam int unsigned REG_MATH = 5;
  localparam int unsigned REG_CNT  = 7;

  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_BGTE = 4;
  localparam int unsigned ALU_BLTZ = 5;
  localparam int unsigned ALU_BEZ  = 6;
  localparam int unsigned ALU_BE   = 7;
  localparam int unsigned ALU_BNE  = 8;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // ALU compare code for a conditional-branch opcode (0 for anything else).
  function automatic int unsigned branch_alu(input int unsigned op);
    case (op)
      OP_BGTE: return ALU_BGTE;
      OP_BLTZ: return ALU_BLTZ;
      OP_BEZ:  return ALU_BEZ;
      OP_BE:   return ALU_BE;
      OP_BNE:  return ALU_BNE;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode decode; every field not driven by an opcode stays 0.
module instr_decoder
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [REG_W-1:0]   rd_reg0,
  output logic [REG_W-1:0]   rd_reg1,
  output logic [REG_W-1:0]   wr_reg,
  output logic               wr_en,
  output logic               move,
  output logic               immediate,
  output logic               set_quarter,
  output logic               branch,
  output logic               jump_sign,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               mem_to_reg,
  output logic               mem_write,
  output logic [1:0]         reg_to_mem,
  output logic               uses_rd0,
  output logic               uses_rd1,
  output logic               is_halt,
  output logic               is_illegal
);

  logic [OPC_W-1:0] opcode;
  logic [REG_W-1:0] fld_a;
  logic [REG_W-1:0] fld_b;

  assign opcode = instr[INSTR_W-1 -: OPC_W];
  assign fld_a  = REG_W'(instr[3:2]);
  assign fld_b  = REG_W'(instr[1:0]);

  always_comb begin
    rd_reg0     = '0;
    rd_reg1     = '0;
    wr_reg      = '0;
    wr_en       = 1'b0;
    move        = 1'b0;
    immediate   = 1'b0;
    set_quarter = 1'b0;
    branch      = 1'b0;
    jump_sign   = 1'b0;
    alu_op      = '0;
    mem_to_reg  = 1'b0;
    mem_write   = 1'b0;
    reg_to_mem  = '0;
    uses_rd0    = 1'b0;
    uses_rd1    = 1'b0;
    is_halt     = 1'b0;
    is_illegal  = (opcode >= OPC_W'(OP_ILLEGAL_MIN));
    case (opcode)
      OPC_W'(OP_ADD), OPC_W'(OP_SUB): begin
        rd_reg0  = fld_a;
        rd_reg1  = REG_W'(REG_MATH);
        wr_reg   = fld_b;
        wr_en    = 1'b1;
        alu_op   = (opcode == OPC_W'(OP_SUB)) ? ALUOP_W'(ALU_SUB) : ALUOP_W'(ALU_ADD);
        uses_rd0 = 1'b1;
        uses_rd1 = 1'b1;
      end
      OPC_W'(OP_MOV): begin
        rd_reg0  = fld_a;
        wr_reg   = fld_b;
        wr_en    = 1'b1;
        move     = 1'b1;
        uses_rd0 = 1'b1;
      end
      OPC_W'(OP_IMM): begin
        wr_reg    = REG_W'(REG_MATH);
        wr_en     = 1'b1;
        immediate = 1'b1;
      end
      OPC_W'(OP_SETQ): set_quarter = 1'b1;
      OPC_W'(OP_CNTDEC): begin
        rd_reg0  = REG_W'(REG_CNT);
        wr_reg   = REG_W'(REG_CNT);
        wr_en    = 1'b1;
        alu_op   = ALUOP_W'(ALU_SUB);
        uses_rd0 = 1'b1;
      end
      OPC_W'(OP_BGTE), OPC_W'(OP_BLTZ), OPC_W'(OP_BEZ), OPC_W'(OP_BE), OPC_W'(OP_BNE): begin
        rd_reg0  = fld_a;
        rd_reg1  = fld_b;
        branch   = 1'b1;
        alu_op   = ALUOP_W'(branch_alu(32'(opcode)));
        uses_rd0 = 1'b1;
        uses_rd1 = 1'b1;
      end
      OPC_W'(OP_JMP): begin
        branch    = 1'b1;
        jump_sign = instr[3];
        alu_op    = ALUOP_W'(ALU_BE);
      end
      OPC_W'(OP_LD): begin
        rd_reg0    = fld_a;
        rd_reg1    = REG_W'(REG_ADR);
        wr_reg     = fld_b;
        wr_en      = 1'b1;
        mem_to_reg = 1'b1;
        uses_rd0   = 1'b1;
        uses_rd1   = 1'b1;
      end
      OPC_W'(OP_ST): begin
        rd_reg0    = fld_a;
        rd_reg1    = REG_W'(REG_ADR);
        reg_to_mem = instr[1:0];
        mem_write  = 1'b1;
        uses_rd0   = 1'b1;
        uses_rd1   = 1'b1;
      end
      OPC_W'(OP_HALT): is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: registered control bundle, load-use bubble, flush and halt/resume.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               flush,
  input  logic               resume,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_W-1:0]   rd_reg0,
  output logic [REG_W-1:0]   rd_reg1,
  output logic [REG_W-1:0]   wr_reg,
  output logic               wr_en,
  output logic               move,
  output logic               immediate,
  output logic               set_quarter,
  output logic               branch,
  output logic               jump_sign,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               mem_to_reg,
  output logic               mem_write,
  output logic [1:0]         reg_to_mem,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic [REG_W-1:0]   rd_reg0;
    logic [REG_W-1:0]   rd_reg1;
    logic [REG_W-1:0]   wr_reg;
    logic               wr_en;
    logic               move;
    logic               immediate;
    logic               set_quarter;
    logic               branch;
    logic               jump_sign;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_to_reg;
    logic               mem_write;
    logic [1:0]         reg_to_mem;
  } bundle_t;

  bundle_t dec_b, bund_q;
  state_t  state_q, state_d;
  logic    uses_rd0, uses_rd1, is_halt, is_illegal;
  logic    hazard, space, run, accept, bubble;

  instr_decoder #(
    .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_W(REG_W), .ALUOP_W(ALUOP_W)
  ) u_dec (
    .instr(instr),
    .rd_reg0(dec_b.rd_reg0), .rd_reg1(dec_b.rd_reg1), .wr_reg(dec_b.wr_reg),
    .wr_en(dec_b.wr_en), .move(dec_b.move), .immediate(dec_b.immediate),
    .set_quarter(dec_b.set_quarter), .branch(dec_b.branch), .jump_sign(dec_b.jump_sign),
    .alu_op(dec_b.alu_op), .mem_to_reg(dec_b.mem_to_reg), .mem_write(dec_b.mem_write),
    .reg_to_mem(dec_b.reg_to_mem),
    .uses_rd0(uses_rd0), .uses_rd1(uses_rd1), .is_halt(is_halt), .is_illegal(is_illegal)
  );

  // Load-use: the held load's destination is a source of the offered instruction.
  assign hazard = in_valid & out_valid & bund_q.mem_to_reg &
                  ((uses_rd0 & (dec_b.rd_reg0 == bund_q.wr_reg)) |
                   (uses_rd1 & (dec_b.rd_reg1 == bund_q.wr_reg)));
  assign run      = (state_q == RUN);
  assign space    = ~out_valid | out_ready;
  assign in_ready = rst_n & (flush | (space & ~hazard & run));
  assign accept   = in_valid & in_ready & ~flush;
  assign bubble   = hazard & out_ready & ~flush & run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bund_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      bund_q    <= '0;
    end else if (accept) begin
      out_valid <= ~(is_halt | is_illegal);
      bund_q    <= (is_halt | is_illegal) ? '0 : dec_b;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      bund_q    <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (accept && is_illegal) illegal <= 1'b1;
      if (bubble && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && is_halt) state_d = HALTED;
      HALTED:  if (resume) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    halted = 1'b0;
    if (state_q == HALTED) halted = 1'b1;
  end

  assign rd_reg0     = bund_q.rd_reg0;
  assign rd_reg1     = bund_q.rd_reg1;
  assign wr_reg      = bund_q.wr_reg;
  assign wr_en       = bund_q.wr_en;
  assign move        = bund_q.move;
  assign immediate   = bund_q.immediate;
  assign set_quarter = bund_q.set_quarter;
  assign branch      = bund_q.branch;
  assign jump_sign   = bund_q.jump_sign;
  assign alu_op      = bund_q.alu_op;
  assign mem_to_reg  = bund_q.mem_to_reg;
  assign mem_write   = bund_q.mem_write;
  assign reg_to_mem  = bund_q.reg_to_mem;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter INSTR_W, default 9, instruction width.
REQ-002 SHALL have parameter OPC_W, default 5, opcode field width, taken from instr[INSTR_W-1 -: OPC_W].
REQ-003 SHALL have parameter REG_W, default 4, register-address width.
REQ-004 SHALL have parameter ALUOP_W, default 4, ALU-op width.
REQ-005 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-006 Ports, in order: name, direction, width, meaning:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, instruction offered.
- in_ready, out, 1, instruction accepted when in_valid and in_ready are both high.
- instr, in, INSTR_W, instruction word.
- flush, in, 1, taken branch in EX; kill the in-flight and incoming instruction.
- resume, in, 1, leave HALTED.
- out_valid, out, 1, registered control bundle valid.
- out_ready, in, 1, EX accepts the bundle.
- rd_reg0, out, REG_W, first read-register address.
- rd_reg1, out, REG_W, second read-register address.
- wr_reg, out, REG_W, destination-register address.
- wr_en, out, 1, register-file write enable.
- move, out, 1, move path.
- immediate, out, 1, immediate path.
- set_quarter, out, 1, quarter-select path.
- branch, out, 1, branch.
- jump_sign, out, 1, jump sign.
- alu_op, out, ALUOP_W, ALU operation.
- mem_to_reg, out, 1, load.
- mem_write, out, 1, store.
- reg_to_mem, out, 2, store data select.
- halted, out, 1, halt state-machine status.
- illegal, out, 1, sticky illegal-opcode flag.
- stall_cnt, out, CNT_W, number of load-use bubbles inserted.

Function
REQ-007 Decode SHALL be fully specified for every opcode: every field not set by an opcode SHALL be 0 (no held or X values).
REQ-008 Decode SHALL use fixed register numbers ADR=4, MATH=5, CNT=7.
REQ-009 Decode field mapping:
- add/sub: rd0=instr[3:2], rd1=MATH, wr=instr[1:0], alu_op 0/1.
- ld: rd0=instr[3:2], rd1=ADR, wr=instr[1:0], mem_to_reg=1.
- st: rd0=instr[3:2], rd1=ADR, reg_to_mem=instr[1:0], mem_write=1, wr_en=0.
- branches: rd0=instr[3:2], rd1=instr[1:0], branch=1, alu_op be=7 bne=8 bez=6 bltz=5 bgte=4.
- jump: branch=1, alu_op=7.
REQ-010 The output bundle SHALL be registered with 1-cycle latency: an instruction accepted at edge N appears with out_valid=1 after edge N.
REQ-011 The bundle SHALL hold stable while out_valid=1 and out_ready=0.
REQ-012 in_ready SHALL be (!out_valid | out_ready) & !hazard & (state==RUN), or 1 when flush=1.
REQ-013 Hazard SHALL be asserted when the held bundle has mem_to_reg=1 and the incoming opcode reads wr_reg through rd_reg0 or rd_reg1.
REQ-014 On a hazard, the stage SHALL emit exactly one bubble (out_valid=0), then accept the instruction.
REQ-015 stall_cnt SHALL increment by 1 per bubble and saturate at all-ones.
REQ-016 flush=1 SHALL:
- clear out_valid at the next edge;
- consume and discard the offered instruction;
- take priority over the hazard and over halt.
REQ-017 The halt state machine SHALL have states RUN and HALTED.
REQ-018 RUN to HALTED SHALL occur when a halt opcode is accepted without flush; the halt bundle itself SHALL not be emitted.
REQ-019 HALTED to RUN SHALL occur on resume=1; in HALTED, in_ready=0 and halted=1.
REQ-020 Opcodes 27..(2^OPC_W-1) SHALL be treated as NOPs (out_valid=0) and SHALL set illegal; illegal clears only on reset.
REQ-021 A simultaneous hazard and out_ready=0 SHALL count a single bubble only, when the bubble is actually inserted.

Reset
REQ-022 While rst_n=0, the stage SHALL asynchronously drive:
- all outputs 0;
- state=RUN;
- stall_cnt=0;
- illegal=0;
- out_valid=0.
REQ-023 A reset in mid-stall or mid-halt SHALL discard the held bundle; first acceptance SHALL be possible at the first edge after release.

Structure
REQ-024 Opcode constants, fixed register numbers, ALU-op codes and the state enum SHALL reside in a shared package, decode_pkg.
REQ-025 Combinational decode SHALL be one sub-module, instr_decoder, with the registers, hazard logic and state machine in decode_stage.

Verification
REQ-026 The bench SHALL cover the following directed scenarios, one line each:
- add 9'b00000_0110 -> next cycle out_valid=1, rd_reg0=1, rd_reg1=5, wr_reg=2, wr_en=1, alu_op=0.
- ld 9'b10110_0111 then add 9'b00000_1100 -> one bubble, then add issues; stall_cnt=1.
- out_ready=0 for 3 cycles with valid bundle -> bundle stable, in_ready=0.
- halt 9'b11010_0000 -> halted=1 next cycle, in_ready=0; resume=1 -> RUN.
- halt accepted with flush=1 -> halted stays 0, out_valid=0.
- opcode 5'b11110 -> illegal=1, no bundle; rst_n low -> illegal=0.
